// File: rtl/aes_iter_sequencer_pkg.sv
// Shared AES-128 types, tables and byte-level round transforms for the
// iterative encryption sequencer.
package aes_iter_sequencer_pkg;

  typedef logic [7:0]    AESByte;
  typedef AESByte [3:0]  AESWord;
  typedef AESWord [3:0]  AESMatrix;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_e;

  localparam AESByte SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam AESByte RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic AESByte xtime(input AESByte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic AESMatrix sub_bytes(input AESMatrix s);
    AESMatrix r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[c][w] = SBOX[s[c][w]];
    return r;
  endfunction

  // Row w rotates left by w columns.
  function automatic AESMatrix shift_rows(input AESMatrix s);
    AESMatrix r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[c][w] = s[(c + w) & 3][w];
    return r;
  endfunction

  function automatic AESMatrix mix_columns(input AESMatrix s);
    AESMatrix r;
    for (int c = 0; c < 4; c++) begin
      r[c][0] = xtime(s[c][0]) ^ xtime(s[c][1]) ^ s[c][1] ^ s[c][2] ^ s[c][3];
      r[c][1] = s[c][0] ^ xtime(s[c][1]) ^ xtime(s[c][2]) ^ s[c][2] ^ s[c][3];
      r[c][2] = s[c][0] ^ s[c][1] ^ xtime(s[c][2]) ^ xtime(s[c][3]) ^ s[c][3];
      r[c][3] = xtime(s[c][0]) ^ s[c][0] ^ s[c][1] ^ s[c][2] ^ xtime(s[c][3]);
    end
    return r;
  endfunction

  function automatic AESMatrix add_round_key(input AESMatrix s, input AESMatrix k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_iter_sequencer_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the
// current one and the round constant.
module aes_key_step
  import aes_iter_sequencer_pkg::*;
(
  input  AESMatrix rk,
  input  AESByte   rcon,
  output AESMatrix rk_next
);

  AESWord rot_sub;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot_sub
      assign rot_sub[gi] = SBOX[rk[3][(gi + 1) % 4]];
    end
  endgenerate

  // Word w of the new key is the running XOR of temp and words 0..w.
  always_comb begin
    AESWord acc;
    acc = rot_sub;
    acc[0] = acc[0] ^ rcon;
    rk_next = '0;
    for (int w = 0; w < 4; w++) begin
      acc = acc ^ rk[w];
      rk_next[w] = acc;
    end
  end

endmodule

// File: rtl/aes_iter_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath reused for NR cycles,
// round keys expanded on the fly, valid/ready on both sides.
module aes_iter_sequencer
  import aes_iter_sequencer_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter bit IN_BYPASS = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  output logic     in_ready,
  input  AESMatrix data,
  input  AESMatrix key,
  output logic     out_valid,
  input  logic     out_ready,
  output AESMatrix o,
  output logic     busy,
  output logic [3:0] round
);

  generate
    if (NR != AES128_NR) begin : g_nr_check
      $error("aes_iter_sequencer supports only NR=10 (AES-128)");
    end
  endgenerate

  localparam logic [3:0] LAST_RUN_ROUND = 4'(NR - 1);
  localparam logic [3:0] FINAL_ROUND    = 4'(NR);

  state_e     state_q;
  AESMatrix   st_q, rk_q, rk_d, sr, mc, st_run_d, st_last_d;
  AESByte     rcon_q;
  logic [3:0] round_q;
  logic       out_valid_q, busy_q;
  logic       load;

  aes_key_step u_key_step (
    .rk      (rk_q),
    .rcon    (rcon_q),
    .rk_next (rk_d)
  );

  always_comb begin
    sr = shift_rows(sub_bytes(st_q));
    mc = mix_columns(sr);
  end

  assign st_run_d  = add_round_key(mc, rk_d);
  assign st_last_d = add_round_key(sr, rk_d);

  assign in_ready = (state_q == S_IDLE) || (IN_BYPASS && state_q == S_DONE && out_ready);
  assign load     = in_valid && in_ready;

  // A load covers both the IDLE accept and the DONE bypass accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      rcon_q      <= '0;
      round_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (load) begin
      state_q     <= S_RUN;
      st_q        <= add_round_key(data, key);
      rk_q        <= key;
      rcon_q      <= RCON[0];
      round_q     <= 4'd1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          st_q    <= st_run_d;
          rk_q    <= rk_d;
          rcon_q  <= xtime(rcon_q);
          round_q <= round_q + 4'd1;
          if (round_q == LAST_RUN_ROUND) state_q <= S_LAST;
        end
        S_LAST: begin
          st_q        <= st_last_d;
          round_q     <= FINAL_ROUND;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o         = st_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign round     = round_q;

endmodule

// File: doc/aes_iter_sequencer.md
Name: aes_iter_sequencer

Overview:
Iterative AES-128 encryption controller. It runs one shared round datapath (subBytes, shiftRows, mixColumns, addRoundKey) for NR cycles, replacing the fully unrolled cipher chain when area matters more than throughput. Round keys are generated on the fly, one key-expansion step per cycle, so no 44-word schedule is stored. Valid/ready handshakes on input and output, one block in flight.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails otherwise.
IN_BYPASS, 1, when 1 a new block may be accepted in the same cycle the finished result is consumed.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  data/key are presented.
in_ready  out  1  block can accept a new data/key pair.
data  in  8x[4][4]  plaintext, [col][row] order; byte i = data[i/4][i%4].
key  in  8x[4][4]  cipher key, same ordering as data.
out_valid  out  1  o holds a finished ciphertext.
out_ready  in  1  downstream accepts o.
o  out  8x[4][4]  ciphertext, same ordering.
busy  out  1  a block is being computed (RUN or LAST).
round  out  4  current round index 0..NR, for debug.

Behaviour:
- FSM states: IDLE, RUN, LAST, DONE. Reset sets IDLE, out_valid=0, busy=0, round=0, o=all zero, and state/rk/rcon registers to zero.
- IDLE: in_ready=1. If in_valid: st <= data ^ key, rk <= key, rcon <= 0x01, round <= 1, go to RUN.
- RUN (round 1..NR-1): rk_n = key_step(rk, rcon); st <= mixColumns(shiftRows(subBytes(st))) ^ rk_n; rk <= rk_n; rcon <= xtime(rcon), reducing with 0x1B when bit 7 is set. round increments. When round == NR-1, go to LAST.
- LAST (round NR): st <= shiftRows(subBytes(st)) ^ key_step(rk, rcon), with no mixColumns. Go to DONE, out_valid <= 1, round <= NR.
- DONE: o = st, held stable while out_valid=1 && out_ready=0.
  - out_ready=1: out_valid <= 0.
  - If IN_BYPASS=1 and in_valid=1 in that same cycle, load the new block exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- in_ready is combinational: (state==IDLE) || (IN_BYPASS && state==DONE && out_ready). It is never asserted in RUN or LAST, and input is ignored there.
- Latency: handshake accepted at edge k gives out_valid=1 after edge k+NR (10 clocks later). Back-to-back throughput with bypass is one block per NR cycles.
- The rcon sequence over rounds 1..10 is 01,02,04,08,10,20,40,80,1B,36. The value after the last round is don't-care.
- busy=1 exactly in RUN and LAST.
- rst=1 in any state, including mid-round or DONE with out_valid pending, returns to IDLE on that edge. The pending result is discarded and out_valid=0 on the next cycle.
- data/key are sampled only on the accepting edge. Later changes on the inputs have no effect on a block in flight.
- All XOR and GF arithmetic is 8-bit bytewise with no width growth.

Decomposition:
- Shared package:
  - AESByte (8 bits), AESWord (4 bytes), AESMatrix (4 words).
  - SBOX table and RCON table.
  - xtime function.
  - NR constant.
  - FSM state enum.
- One sub-module, aes_key_step: input rk (AESMatrix) and rcon (AESByte), output the next round key (AESMatrix); purely combinational, using RotWord, SubWord and the rcon XOR on word 0, then the chained word XORs.
- Reuse the existing subBytes, shiftRows, mixColumns and addRoundKey modules as single combinational instances.

Test Plan:
- FIPS-197 App. B: data=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 → o=3925841d02dc09fbdc118597196a0b32 with out_valid high exactly 10 clocks after acceptance; busy high for 10 cycles.
- FIPS-197 App. C.1: data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f → o=69c4e0d86a7b0430d8cdb78070b4c55a; round steps 1..10.
- Backpressure: out_ready=0 for 5 cycles after out_valid → o and out_valid stable, in_ready=0. Raise out_ready → out_valid drops the next cycle.
- Bypass: App. B block, then App. C.1 held on in_valid while out_ready=1 in DONE → second block accepted the same cycle, and both results arrive in order 10 cycles apart.
- Input ignored while busy: toggle data/key and pulse in_valid during RUN → result still equals the App. B ciphertext.
- Reset mid-operation: assert rst at round 5 → next cycle IDLE, out_valid=0, in_ready=1. A subsequent App. B run still gives the correct ciphertext.
